cascade_mod_counter: RTL and testbench

Parametrised multi-digit cascaded modulo counter. Each digit has its own modulus, and each digit's rollover drives the next digit's step.
Supports up/down counting, synchronous clear, synchronous parallel load with range checking, and a sticky overflow flag.
Used for timer and clock displays (default configuration: mm:ss, BCD digits). It replaces chains of hand-wired single-digit counters.

---
 rtl/cascade_mod_counter.sv | 114 +++++++++++
 tb/tb_cascade_mod_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_mod_counter.sv
// Cascaded multi-digit modulo counter. Each digit has its own modulus and
// steps when every less-significant digit wraps in the same cycle. Supports
// up/down counting, synchronous clear, range-checked parallel load, a sticky
// whole-counter overflow flag and a one-cycle load error pulse.
module cascade_mod_counter #(
  parameter int                          NUM_DIGITS = 4,
  parameter int                          DIGIT_W    = 4,
  parameter logic [8*NUM_DIGITS-1:0]     MOD_VALUES = {8'd6, 8'd10, 8'd6, 8'd10}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            enable,
  input  logic                            down,
  input  logic                            load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_value,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   count,
  output logic [NUM_DIGITS-1:0]           carry,
  output logic                            terminal,
  output logic                            overflow,
  output logic                            load_error
);

  // Range checks are done at the wider of the digit width and the 8-bit
  // modulus field, so neither operand is truncated.
  localparam int CW = (DIGIT_W > 8) ? DIGIT_W : 8;

  logic [NUM_DIGITS*DIGIT_W-1:0] count_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] step_count;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_count;
  logic [NUM_DIGITS-1:0]         carry_c;
  logic                          any_sat;
  logic                          overflow_q;
  logic                          load_error_q;

  // Largest legal value of digit i, in digit width.
  function automatic logic [DIGIT_W-1:0] digit_max(input int i);
    logic [7:0] m;
    m = MOD_VALUES[8*i +: 8] - 8'd1;
    return DIGIT_W'(m);
  endfunction

  // Ripple the step request through the digits and compute both the stepped
  // and the saturated-load next values.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    logic              step;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] dmax;
    logic [DIGIT_W-1:0] lv;
    logic              at_edge;
    step       = enable & ~clear & ~load;
    step_count = count_q;
    load_count = '0;
    carry_c    = '0;
    any_sat    = 1'b0;
    digit      = '0;
    dmax       = '0;
    lv         = '0;
    at_edge    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit   = count_q[DIGIT_W*i +: DIGIT_W];
      dmax    = digit_max(i);
      at_edge = down ? (digit == '0) : (digit == dmax);
      carry_c[i] = step & at_edge;
      if (step) begin
        if (at_edge) step_count[DIGIT_W*i +: DIGIT_W] = down ? dmax : '0;
        else         step_count[DIGIT_W*i +: DIGIT_W] = down ? digit - DIGIT_W'(1)
                                                             : digit + DIGIT_W'(1);
      end
      // Only a digit that wrapped passes the step on to the next one.
      step = carry_c[i];

      lv = load_value[DIGIT_W*i +: DIGIT_W];
      if (CW'(lv) < CW'(MOD_VALUES[8*i +: 8])) begin
        load_count[DIGIT_W*i +: DIGIT_W] = lv;
      end else begin
        load_count[DIGIT_W*i +: DIGIT_W] = dmax;
        any_sat = 1'b1;
      end
    end
  end

  // State register: clear beats load beats step.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      overflow_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else if (clear) begin
      count_q      <= '0;
      overflow_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else if (load) begin
      count_q      <= load_count;
      overflow_q   <= 1'b0;
      load_error_q <= any_sat;
    end else begin
      count_q      <= step_count;
      load_error_q <= 1'b0;
      if (carry_c[NUM_DIGITS-1]) overflow_q <= 1'b1;
    end
  end

  assign count      = count_q;
  assign carry      = carry_c;
  assign terminal   = carry_c[NUM_DIGITS-1];
  assign overflow   = overflow_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Directed testbench for cascade_mod_counter in its default mm:ss
// configuration (digit moduli 10, 6, 10, 6 from least significant up).
module tb_cascade_mod_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        enable;
  logic        down;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic [3:0]  carry;
  logic        terminal;
  logic        overflow;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  cascade_mod_counter dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .enable     (enable),
    .down       (down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .carry      (carry),
    .terminal   (terminal),
    .overflow   (overflow),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    tick();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; enable = 1'b0; down = 1'b0;
    load = 1'b0; load_value = '0;
    tick(); tick();
    checks++;
    if (count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", count); end
    checks++;
    if (overflow !== 1'b0 || load_error !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b lerr=%b want 0 0", overflow, load_error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_count();
    // Wrap once so overflow is set, then count up to 00:42.
    do_load(16'h5959);
    enable = 1'b1;
    tick();
    for (int k = 0; k < 42; k++) tick();
    checks++;
    if (count !== 16'h0042 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got %h ovf=%b want 0042 ovf=1", count, overflow);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 16'h0000 || overflow !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h ovf=%b want 0000 ovf=0", count, overflow);
    end
    reset = 1'b0;
    tick();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0001) begin errors++; $display("FAIL post_reset_step: got %h want 0001", count); end
  endtask

  task automatic test_up_wrap();
    do_load(16'h5959);
    down = 1'b0; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 4'b1111 || terminal !== 1'b1) begin
      errors++; $display("FAIL up_wrap_carry: got carry=%b term=%b want 1111 1", carry, terminal);
    end
    tick();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0000 || overflow !== 1'b1) begin
      errors++; $display("FAIL up_wrap_count: got %h ovf=%b want 0000 ovf=1", count, overflow);
    end
  endtask

  task automatic test_down_wrap();
    do_load(16'h0000);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL load_clears_ovf: got %b want 0", overflow); end
    down = 1'b1; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 4'b1111 || terminal !== 1'b1) begin
      errors++; $display("FAIL down_wrap_carry: got carry=%b term=%b want 1111 1", carry, terminal);
    end
    tick();
    enable = 1'b0; down = 1'b0;
    checks++;
    if (count !== 16'h5959 || overflow !== 1'b1) begin
      errors++; $display("FAIL down_wrap_count: got %h ovf=%b want 5959 ovf=1", count, overflow);
    end
  endtask

  task automatic test_partial_carry();
    do_load(16'h0359);
    down = 1'b0; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 4'b0011 || terminal !== 1'b0) begin
      errors++; $display("FAIL partial_carry: got carry=%b term=%b want 0011 0", carry, terminal);
    end
    tick();
    enable = 1'b0;
    checks++;
    if (count !== 16'h0400) begin errors++; $display("FAIL partial_count: got %h want 0400", count); end
    checks++;
    if (carry !== 4'b0000) begin errors++; $display("FAIL idle_carry: got %b want 0000", carry); end
    tick();
    checks++;
    if (count !== 16'h0400 || overflow !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got %h ovf=%b want 0400 ovf=0", count, overflow);
    end
    // Borrow back down across two digits.
    down = 1'b1; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 4'b0011) begin errors++; $display("FAIL down_partial_carry: got %b want 0011", carry); end
    tick();
    enable = 1'b0; down = 1'b0;
    checks++;
    if (count !== 16'h0359) begin errors++; $display("FAIL down_partial_count: got %h want 0359", count); end
  endtask

  task automatic test_illegal_load();
    // Set overflow first, then load with enable held high (it must be ignored).
    do_load(16'h5959);
    enable = 1'b1;
    tick();
    load = 1'b1; load_value = 16'h3A7B;
    #1;
    checks++;
    if (carry !== 4'b0000 || terminal !== 1'b0) begin
      errors++; $display("FAIL load_carry: got carry=%b term=%b want 0000 0", carry, terminal);
    end
    tick();
    load = 1'b0; enable = 1'b0;
    checks++;
    if (count !== 16'h3959) begin errors++; $display("FAIL sat_load_count: got %h want 3959", count); end
    checks++;
    if (load_error !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL sat_load_flags: got lerr=%b ovf=%b want 1 0", load_error, overflow);
    end
    tick();
    checks++;
    if (load_error !== 1'b0) begin errors++; $display("FAIL lerr_pulse: got %b want 0", load_error); end
    // Every digit out of range saturates to its maximum.
    do_load(16'h7A8C);
    checks++;
    if (count !== 16'h5959 || load_error !== 1'b1) begin
      errors++; $display("FAIL all_sat: got %h lerr=%b want 5959 1", count, load_error);
    end
    do_load(16'h2508);
    checks++;
    if (count !== 16'h2508 || load_error !== 1'b0) begin
      errors++; $display("FAIL legal_load: got %h lerr=%b want 2508 0", count, load_error);
    end
  endtask

  task automatic test_priority();
    do_load(16'h5959);
    clear = 1'b1; load = 1'b1; load_value = 16'h7A8C; enable = 1'b1;
    #1;
    checks++;
    if (carry !== 4'b0000 || terminal !== 1'b0) begin
      errors++; $display("FAIL prio_carry: got carry=%b term=%b want 0000 0", carry, terminal);
    end
    tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    checks++;
    if (count !== 16'h0000 || overflow !== 1'b0 || load_error !== 1'b0) begin
      errors++; $display("FAIL prio_state: got %h ovf=%b lerr=%b want 0000 0 0", count, overflow, load_error);
    end
    // Clear alone drops a set overflow flag.
    down = 1'b1; enable = 1'b1;
    tick();
    enable = 1'b0; down = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count !== 16'h0000 || overflow !== 1'b0) begin
      errors++; $display("FAIL clear_ovf: got %h ovf=%b want 0000 0", count, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_seq [5];
    logic        dir_seq [5];
    exp_seq = '{16'h0059, 16'h0100, 16'h0101, 16'h0100, 16'h0059};
    dir_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_load(16'h0058);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      down = dir_seq[k];
      tick();
      checks++;
      if (count !== exp_seq[k]) begin
        errors++; $display("FAIL back_to_back[%0d]: got %h want %h", k, count, exp_seq[k]);
      end
    end
    enable = 1'b0; down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_up_wrap();
    test_down_wrap();
    test_partial_carry();
    test_illegal_load();
    test_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
